// File: rtl/rv_pkg.sv
// Shared constants for the RISC-V core: datapath width, instruction size,
// default reset vector and the major opcodes decoded by the control unit.
package rv_pkg;

  localparam int WIDTH       = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WIDTH-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Branch targets are forced onto an instruction boundary.
  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction ROM port, fetched-instruction output and the
// branch/stall controls coming back from the control unit.
interface fetch_unit_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  stall;
    logic                  pcsrc;
    logic [WIDTH-1:0]      immop;
    logic                  imem_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0]      imem_rdata;
    logic [WIDTH-1:0]      instr;
    logic [WIDTH-1:0]      instr_pc;
    logic                  instr_valid;

    // Handshake: instr/instr_pc are meaningful only while instr_valid=1; there
    // is no ready, the consumer back-pressures with stall, which freezes every
    // fetch register, and pcsrc is only sampled with instr_valid=1 and stall=0.
    modport master (
        input  stall, pcsrc, immop, imem_rdata,
        output imem_en, imem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output stall, pcsrc, immop, imem_rdata,
        input  imem_en, imem_addr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: async reset to the reset vector, +4 per unstalled cycle,
// or loads the redirect target.
module pc_reg #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_q
);
    import rv_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (!hold) begin
            pc_q <= load ? target : pc_q + WIDTH'(INSTR_BYTES);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC to a synchronous ROM, tracks the
// in-flight request and registers the returned word with its address.
module fetch_unit #(
    parameter int                       WIDTH      = rv_pkg::WIDTH,
    parameter int                       ADDR_WIDTH = 8,
    parameter logic [rv_pkg::WIDTH-1:0] RESET_PC   = rv_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    import rv_pkg::*;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] req_pc_q;
    logic             req_valid_q;
    logic             redirect;
    logic [WIDTH-1:0] target;

    assign redirect      = bus.pcsrc & bus.instr_valid & !bus.stall;
    assign target        = word_align(bus.instr_pc + bus.immop);
    assign bus.imem_en   = !bus.stall;
    assign bus.imem_addr = pc_q[ADDR_WIDTH+1:2];

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .hold   (bus.stall),
        .load   (redirect),
        .target (target),
        .pc_q   (pc_q)
    );

    // A redirect kills both the request issued this cycle and the response
    // landing this cycle, giving the two-bubble taken-branch penalty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q     <= 1'b0;
            req_pc_q        <= '0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
        end else if (!bus.stall) begin
            req_valid_q     <= !redirect;
            req_pc_q        <= pc_q;
            bus.instr       <= bus.imem_rdata;
            bus.instr_pc    <= req_pc_q;
            bus.instr_valid <= req_valid_q & !redirect;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random run,
// all compared against a queue-based model of the fetch stream.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] rom [256];
  logic [31:0] m_next_pc;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [32:0] m_q[$];

  fetch_unit_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

  fetch_unit #(.WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset / ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];
  end

  task automatic model_clear();
    m_next_pc = 32'h0;
    m_valid   = 1'b0;
    m_pc      = 32'h0;
    m_q.delete();
  endtask

  task automatic load_rom_linear();
    for (int i = 0; i < 256; i++) rom[i] = 32'h100 + i;
  endtask

  task automatic do_reset();
    bus.stall = 1'b0;
    bus.pcsrc = 1'b0;
    bus.immop = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare against model, advance model and clock.
  task automatic step(input logic s, input logic p, input logic [31:0] imm);
    logic [32:0] e;
    logic        taken;
    logic [31:0] tgt;
    bus.stall = s;
    bus.pcsrc = p;
    bus.immop = imm;
    #1;
    checks++;
    if (bus.imem_en !== !s) begin
      errors++;
      $display("FAIL imem_en got %b exp %b", bus.imem_en, !s);
    end
    if (!s) begin
      checks++;
      if (bus.imem_addr !== m_next_pc[9:2]) begin
        errors++;
        $display("FAIL imem_addr got %h exp %h", bus.imem_addr, m_next_pc[9:2]);
      end
    end
    checks++;
    if (bus.instr_valid !== m_valid) begin
      errors++;
      $display("FAIL instr_valid got %b exp %b (exp pc %h)", bus.instr_valid, m_valid, m_pc);
    end
    if (m_valid) begin
      checks++;
      if (bus.instr !== rom[m_pc[9:2]] || bus.instr_pc !== m_pc) begin
        errors++;
        $display("FAIL instr got %h@%h exp %h@%h", bus.instr, bus.instr_pc, rom[m_pc[9:2]], m_pc);
      end
    end
    if (!s) begin
      taken = p && m_valid;
      tgt   = (m_pc + imm) & 32'hFFFF_FFFC;
      m_q.push_back({1'b1, m_next_pc});
      e = '0;
      if (m_q.size() > 1) e = m_q.pop_front();
      if (taken) m_q[0][32] = 1'b0;
      m_valid   = e[32] && !taken;
      m_pc      = e[31:0];
      m_next_pc = taken ? tgt : m_next_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    load_rom_linear();
    bus.stall = 1'b0;
    bus.pcsrc = 1'b0;
    bus.immop = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %h/%h/%b exp 0/0/0", bus.instr, bus.instr_pc, bus.instr_valid);
    end
    checks++;
    if (bus.imem_addr !== 8'h0 || bus.imem_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_imem got %h/%b exp 00/1", bus.imem_addr, bus.imem_en);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    load_rom_linear();
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.instr !== 32'h100 + k || bus.instr_pc !== 4 * k || bus.instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d got %h@%h v%b exp %h@%h v1", k, bus.instr, bus.instr_pc,
                 bus.instr_valid, 32'h100 + k, 4 * k);
      end
      step(0, 0, 0);
    end
  endtask

  task automatic test_branch_and_bubble_pcsrc();
    load_rom_linear();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(0, 1, 32'hFFFF_FFF8);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_bubble1 got %b exp 0", bus.instr_valid);
    end
    step(0, 1, 32'd100);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_bubble2 got %b exp 0", bus.instr_valid);
    end
    step(0, 0, 0);
    checks++;
    if (bus.instr !== 32'h100 || bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_target got %h@%h v%b exp 100@0 v1", bus.instr, bus.instr_pc, bus.instr_valid);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0);
  endtask

  task automatic test_stall();
    load_rom_linear();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      checks++;
      if (bus.instr !== 32'h101 || bus.instr_pc !== 32'h4 || bus.instr_valid !== 1'b1 || bus.imem_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got %h@%h v%b en%b exp 101@4 v1 en0", i, bus.instr,
                 bus.instr_pc, bus.instr_valid, bus.imem_en);
      end
    end
    step(0, 0, 0);
    checks++;
    if (bus.instr !== 32'h102 || bus.instr_pc !== 32'h8) begin
      errors++;
      $display("FAIL stall_resume got %h@%h exp 102@8", bus.instr, bus.instr_pc);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0);
  endtask

  task automatic test_misaligned();
    load_rom_linear();
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'd6);
    bus.pcsrc = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr !== 8'd1) begin
      errors++;
      $display("FAIL misaligned_addr got %h exp 01", bus.imem_addr);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (bus.instr !== 32'h101 || bus.instr_pc !== 32'h4 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_target got %h@%h v%b exp 101@4 v1", bus.instr, bus.instr_pc, bus.instr_valid);
    end
  endtask

  task automatic test_wrap();
    load_rom_linear();
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
  endtask

  task automatic test_reset_mid_branch();
    load_rom_linear();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(0, 1, 32'hFFFF_FFF8);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %h/%h/%b exp 0/0/0", bus.instr, bus.instr_pc, bus.instr_valid);
    end
    @(negedge clk);
    model_clear();
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (bus.instr !== 32'h100 || bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_refetch got %h@%h v%b exp 100@0 v1", bus.instr, bus.instr_pc, bus.instr_valid);
    end
    step(0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] imm;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      imm = 32'($urandom_range(0, 80)) - 32'd40;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, imm);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    model_clear();
    test_reset();
    test_sequential();
    test_branch_and_bubble_pcsrc();
    test_stall();
    test_misaligned();
    test_wrap();
    test_reset_mid_branch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
